stream_median3: RTL

Horizontal 3-tap per-channel median filter on the 24-bit Avalon-ST video stream. It sits directly upstream of the image-processing/colour-detect stage, between the camera VIP output and the detector sink. It removes single-pixel salt/pepper noise so detection runs of adjacent pixels are not broken. Control packets, non-video packets and bypass frames pass through unchanged with the same output register stage.

---
 rtl/stream_median3.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/stream_median3.sv
// Horizontal 3-tap per-channel median filter on a 24-bit Avalon-ST video stream.
// Control, non-video and bypass packets pass through the same output register unchanged.
module stream_median3 #(
    parameter int IMAGE_W = 640,
    parameter int CH_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [3*CH_W-1:0]   sink_data,
    input  logic                sink_valid,
    output logic                sink_ready,
    input  logic                sink_sop,
    input  logic                sink_eop,
    output logic [3*CH_W-1:0]   source_data,
    output logic                source_valid,
    input  logic                source_ready,
    output logic                source_sop,
    output logic                source_eop
);

    localparam int XW = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMAGE_W - 1);

    typedef enum logic [1:0] {
        ST_PASS  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    function automatic logic [CH_W-1:0] med3_ch(input logic [CH_W-1:0] a,
                                                input logic [CH_W-1:0] b,
                                                input logic [CH_W-1:0] c);
        logic [CH_W-1:0] lo_ab;
        logic [CH_W-1:0] hi_ab;
        logic [CH_W-1:0] lo_hc;
        lo_ab = (a < b) ? a : b;
        hi_ab = (a < b) ? b : a;
        lo_hc = (hi_ab < c) ? hi_ab : c;
        return (lo_ab > lo_hc) ? lo_ab : lo_hc;
    endfunction

    function automatic logic [3*CH_W-1:0] med3_pix(input logic [3*CH_W-1:0] a,
                                                   input logic [3*CH_W-1:0] b,
                                                   input logic [3*CH_W-1:0] c);
        logic [3*CH_W-1:0] r;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            r[i*CH_W +: CH_W] = med3_ch(a[i*CH_W +: CH_W], b[i*CH_W +: CH_W], c[i*CH_W +: CH_W]);
        end
        return r;
    endfunction

    state_t             state_r;
    logic [XW-1:0]      x_r;
    logic [3*CH_W-1:0]  cur_r;
    logic [3*CH_W-1:0]  prev_r;
    logic               filt_r;
    logic               pend_eop_r;

    logic               free_s;
    logic               accept_s;
    logic               line_end_s;
    logic               hdr_filt_s;
    logic [3*CH_W-1:0]  med_s;

    // Handshake and datapath helpers derived from current state and inputs.
    always_comb begin
        free_s     = ~source_valid | source_ready;
        sink_ready = free_s & (state_r != ST_FLUSH) & ~reset;
        accept_s   = sink_valid & sink_ready;
        line_end_s = (x_r == X_LAST) | sink_eop;
        hdr_filt_s = enable & (sink_data[3:0] == 4'h0);
        med_s      = med3_pix(prev_r, cur_r, sink_data);
    end

    // Line state machine and output register; the register holds while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_PASS;
            x_r          <= '0;
            cur_r        <= '0;
            prev_r       <= '0;
            filt_r       <= 1'b0;
            pend_eop_r   <= 1'b0;
            source_valid <= 1'b0;
            source_data  <= '0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
        end else begin
            if (free_s) begin
                source_valid <= 1'b0;
            end
            case (state_r)
                ST_FLUSH: begin
                    // Last pixel of the line: med(prev,cur,cur) is cur itself.
                    if (free_s) begin
                        source_valid <= 1'b1;
                        source_data  <= cur_r;
                        source_sop   <= 1'b0;
                        source_eop   <= pend_eop_r;
                        x_r          <= '0;
                        state_r      <= pend_eop_r ? ST_PASS : ST_FILL;
                    end
                end
                default: begin
                    if (accept_s) begin
                        if (sink_sop) begin
                            source_valid <= 1'b1;
                            source_data  <= sink_data;
                            source_sop   <= 1'b1;
                            source_eop   <= sink_eop;
                            filt_r       <= hdr_filt_s;
                            x_r          <= '0;
                            cur_r        <= '0;
                            prev_r       <= '0;
                            state_r      <= (hdr_filt_s & ~sink_eop) ? ST_FILL : ST_PASS;
                        end else if ((state_r == ST_FILL) && filt_r) begin
                            cur_r  <= sink_data;
                            prev_r <= sink_data;
                            if (line_end_s) begin
                                pend_eop_r <= sink_eop;
                                state_r    <= ST_FLUSH;
                            end else begin
                                x_r     <= x_r + XW'(1);
                                state_r <= ST_RUN;
                            end
                        end else if ((state_r == ST_RUN) && filt_r) begin
                            source_valid <= 1'b1;
                            source_data  <= med_s;
                            source_sop   <= 1'b0;
                            source_eop   <= 1'b0;
                            prev_r       <= cur_r;
                            cur_r        <= sink_data;
                            if (line_end_s) begin
                                pend_eop_r <= sink_eop;
                                state_r    <= ST_FLUSH;
                            end else begin
                                x_r <= x_r + XW'(1);
                            end
                        end else begin
                            source_valid <= 1'b1;
                            source_data  <= sink_data;
                            source_sop   <= sink_sop;
                            source_eop   <= sink_eop;
                        end
                    end
                end
            endcase
        end
    end

endmodule
